// File: rtl/vj_cascade_seq_if.sv
`default_nettype none
// ============================================================================
// Module : vj_cascade_seq_if
// Brief  : Window-in / feature-ROM / result bundle for the cascade sequencer.
// Rev    : 1.0
// ============================================================================
interface vj_cascade_seq_if #(
    parameter int WIN_SIZE  = 24,
    parameter int DATA_W    = 32,
    parameter int NUM_STAGE = 25,
    parameter int FEAT_AW   = 12
);
    localparam int c_NWORD  = (WIN_SIZE + 1) * (WIN_SIZE + 1);
    // descriptor, msb first: 3 x {x1,y1,x2,y2,weight}, feat_thresh, above, below, stage_thresh, stage_last
    localparam int c_DESC_W = 3 * (20 + DATA_W) + 4 * DATA_W + 1;
    localparam int c_SP_W   = $clog2(NUM_STAGE + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic [c_NWORD*DATA_W-1:0]   scan_win;
    logic [DATA_W-1:0]           std_dev;
    logic [63:0]                 scan_win_index;
    logic [3:0]                  img_index;
    logic [FEAT_AW-1:0]          feat_addr;
    logic                        feat_rd;
    logic [c_DESC_W-1:0]         feat_rdata;
    logic                        out_valid;
    logic                        out_ready;
    logic [63:0]                 top_left;
    logic [3:0]                  pyramid_number;
    logic                        is_face;
    logic [DATA_W-1:0]           accum;
    logic [c_SP_W-1:0]           stages_passed;

    modport slave (
        input  in_valid, scan_win, std_dev, scan_win_index, img_index, feat_rdata, out_ready,
        output in_ready, feat_addr, feat_rd, out_valid, top_left, pyramid_number, is_face,
               accum, stages_passed
    );

    modport master (
        output in_valid, scan_win, std_dev, scan_win_index, img_index, feat_rdata, out_ready,
        input  in_ready, feat_addr, feat_rd, out_valid, top_left, pyramid_number, is_face,
               accum, stages_passed
    );
endinterface
`default_nettype wire

// File: rtl/vj_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module : vj_cascade_seq
// Brief  : Viola-Jones cascade evaluator, one Haar feature per clock.
// Rev    : 1.0
// ============================================================================
module vj_cascade_seq #(
    parameter int WIN_SIZE    = 24,
    parameter int DATA_W      = 32,
    parameter int NUM_FEATURE = 2913,
    parameter int NUM_STAGE   = 25,
    parameter int FEAT_AW     = 12,
    parameter int EARLY_EXIT  = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    vj_cascade_seq_if.slave bus
);
    localparam int                 c_NWORD  = (WIN_SIZE + 1) * (WIN_SIZE + 1);
    localparam int                 c_RECT_W = 20 + DATA_W;
    localparam int                 c_FIX_W  = 4 * DATA_W + 1;
    localparam int                 c_SP_W   = $clog2(NUM_STAGE + 1);
    localparam logic [FEAT_AW-1:0] c_LAST_K = FEAT_AW'(NUM_FEATURE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_out_of_rst;
    logic [c_NWORD*DATA_W-1:0] r_win;
    logic [DATA_W-1:0]         r_std_dev;
    logic [63:0]               r_win_index;
    logic [3:0]                r_img_index;
    logic [FEAT_AW-1:0]        r_k;
    logic [DATA_W-1:0]         r_stage_acc;
    logic [DATA_W-1:0]         r_accum;
    logic [c_SP_W-1:0]         r_stages_passed;
    logic                      r_any_fail;
    logic                      r_is_face;

    logic                      w_feat_rd;
    logic [FEAT_AW-1:0]        w_feat_addr;
    logic [2:0][DATA_W-1:0]    w_rect_term;
    logic                      w_stage_last;
    logic [DATA_W-1:0]         w_stage_thresh, w_below, w_above, w_feat_thresh;
    logic [DATA_W-1:0]         w_sum, w_prod, w_feat_val, w_stage_tot;
    logic                      w_last_feat, w_stage_end, w_pass, w_early_fail, w_finish;
    logic                      w_accept;

    // Integral-image lookup; any coordinate past the window edge reads zero.
    function automatic logic [DATA_W-1:0] f_ii(input logic [4:0] y, input logic [4:0] x);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int yy = 0; yy <= WIN_SIZE; yy++) begin
            for (int xx = 0; xx <= WIN_SIZE; xx++) begin
                if (int'(y) == yy && int'(x) == xx)
                    v = r_win[(yy * (WIN_SIZE + 1) + xx) * DATA_W +: DATA_W];
            end
        end
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_rect
        localparam int c_BASE = c_FIX_W + (2 - g) * c_RECT_W;
        logic [DATA_W-1:0] w_weight;
        logic [DATA_W-1:0] w_area;
        logic [4:0]        w_x1, w_y1, w_x2, w_y2;

        assign w_weight = bus.feat_rdata[c_BASE +: DATA_W];
        assign w_y2     = bus.feat_rdata[c_BASE + DATA_W      +: 5];
        assign w_x2     = bus.feat_rdata[c_BASE + DATA_W + 5  +: 5];
        assign w_y1     = bus.feat_rdata[c_BASE + DATA_W + 10 +: 5];
        assign w_x1     = bus.feat_rdata[c_BASE + DATA_W + 15 +: 5];
        assign w_area   = f_ii(w_y2, w_x2) + f_ii(w_y1, w_x1)
                        - f_ii(w_y1, w_x2) - f_ii(w_y2, w_x1);
        assign w_rect_term[g] = w_area * w_weight;
    end

    assign w_stage_last   = bus.feat_rdata[0];
    assign w_stage_thresh = bus.feat_rdata[1 +: DATA_W];
    assign w_below        = bus.feat_rdata[1 + DATA_W +: DATA_W];
    assign w_above        = bus.feat_rdata[1 + 2 * DATA_W +: DATA_W];
    assign w_feat_thresh  = bus.feat_rdata[1 + 3 * DATA_W +: DATA_W];

    assign w_sum        = w_rect_term[0] + w_rect_term[1] + w_rect_term[2];
    assign w_prod       = w_feat_thresh * r_std_dev;
    assign w_feat_val   = ($signed(w_sum) > $signed(w_prod)) ? w_above : w_below;
    assign w_stage_tot  = r_stage_acc + w_feat_val;
    assign w_last_feat  = (r_k == c_LAST_K);
    assign w_stage_end  = w_stage_last | w_last_feat;
    assign w_pass       = $signed(w_stage_tot) > $signed(w_stage_thresh);
    assign w_early_fail = (EARLY_EXIT != 0) && w_stage_end && !w_pass;
    // The read for k+1 is suppressed in the same cycle the decision to stop is made.
    assign w_finish     = w_last_feat | w_early_fail;
    assign w_accept     = (r_state == IDLE) && r_out_of_rst && bus.in_valid;

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_feat_rd   = 1'b0;
        w_feat_addr = '0;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = FETCH;
            FETCH: begin
                w_feat_rd   = 1'b1;
                w_state_nxt = EVAL;
            end
            EVAL: begin
                w_feat_addr = r_k + 1'b1;
                w_feat_rd   = !w_finish;
                if (w_finish) w_state_nxt = DONE;
            end
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_win     <= bus.scan_win;
            r_std_dev <= bus.std_dev;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_of_rst    <= 1'b0;
            r_win_index     <= '0;
            r_img_index     <= '0;
            r_k             <= '0;
            r_stage_acc     <= '0;
            r_accum         <= '0;
            r_stages_passed <= '0;
            r_any_fail      <= 1'b0;
            r_is_face       <= 1'b0;
        end else begin
            r_out_of_rst <= 1'b1;
            if (w_accept) begin
                r_win_index     <= bus.scan_win_index;
                r_img_index     <= bus.img_index;
                r_k             <= '0;
                r_stage_acc     <= '0;
                r_accum         <= '0;
                r_stages_passed <= '0;
                r_any_fail      <= 1'b0;
                r_is_face       <= 1'b0;
            end else if (r_state == EVAL) begin
                r_k <= r_k + 1'b1;
                if (w_stage_end) begin
                    r_accum     <= r_accum + w_stage_tot;
                    r_stage_acc <= '0;
                    if (w_pass) r_stages_passed <= r_stages_passed + 1'b1;
                    else        r_any_fail      <= 1'b1;
                end else begin
                    r_stage_acc <= w_stage_tot;
                end
                if (w_last_feat) r_is_face <= !r_any_fail && w_pass;
            end
        end
    end

    assign bus.in_ready       = (r_state == IDLE) && r_out_of_rst;
    assign bus.out_valid      = (r_state == DONE);
    assign bus.feat_rd        = w_feat_rd;
    assign bus.feat_addr      = w_feat_addr;
    assign bus.top_left       = r_win_index;
    assign bus.pyramid_number = r_img_index;
    assign bus.is_face        = r_is_face;
    assign bus.accum          = r_accum;
    assign bus.stages_passed  = r_stages_passed;
endmodule
`default_nettype wire

// File: tb/tb_vj_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_vj_cascade_seq
// Brief  : Bench for vj_cascade_seq; instance 0 exits early, instance 1 does not.
// Rev    : 1.0
// ============================================================================
module tb_vj_cascade_seq;
    localparam int c_WIN    = 2;
    localparam int c_DW     = 32;
    localparam int c_NF     = 3;
    localparam int c_NS     = 2;
    localparam int c_AW     = 4;
    localparam int c_NWORD  = (c_WIN + 1) * (c_WIN + 1);
    localparam int c_DESC_W = 3 * (20 + c_DW) + 4 * c_DW + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                      reset_n;
    logic [1:0]                in_valid, out_ready;
    logic [c_NWORD*c_DW-1:0]   scan_win;
    logic [c_DW-1:0]           std_dev;
    logic [63:0]               scan_win_index;
    logic [3:0]                img_index;
    logic [c_DESC_W-1:0]       rom [16];

    wire [1:0]             ir, ov, frd, face_o;
    wire [1:0][c_AW-1:0]   addr_o;
    wire [1:0][c_DW-1:0]   acc_o;
    wire [1:0][1:0]        sp_o;
    wire [1:0][63:0]       tl_o;
    wire [1:0][3:0]        pn_o;
    wire [1:0][15:0]       rdmask_o;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vj_cascade_seq_if #(.WIN_SIZE(c_WIN), .DATA_W(c_DW), .NUM_STAGE(c_NS), .FEAT_AW(c_AW)) bus ();
        logic [15:0] rd_mask = '0;

        assign bus.in_valid       = in_valid[g];
        assign bus.out_ready      = out_ready[g];
        assign bus.scan_win       = scan_win;
        assign bus.std_dev        = std_dev;
        assign bus.scan_win_index = scan_win_index;
        assign bus.img_index      = img_index;

        // ROM with one cycle of read latency; also logs which addresses were read
        always @(posedge clock) begin
            if (bus.in_valid && bus.in_ready) rd_mask <= '0;
            else if (bus.feat_rd)             rd_mask[bus.feat_addr] <= 1'b1;
            if (bus.feat_rd) bus.feat_rdata <= rom[bus.feat_addr];
        end

        assign ir[g]       = bus.in_ready;
        assign ov[g]       = bus.out_valid;
        assign frd[g]      = bus.feat_rd;
        assign addr_o[g]   = bus.feat_addr;
        assign face_o[g]   = bus.is_face;
        assign acc_o[g]    = bus.accum;
        assign sp_o[g]     = bus.stages_passed;
        assign tl_o[g]     = bus.top_left;
        assign pn_o[g]     = bus.pyramid_number;
        assign rdmask_o[g] = rd_mask;

        vj_cascade_seq #(
            .WIN_SIZE(c_WIN), .DATA_W(c_DW), .NUM_FEATURE(c_NF), .NUM_STAGE(c_NS),
            .FEAT_AW(c_AW), .EARLY_EXIT(g == 0 ? 1 : 0)
        ) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    // reference content: window and per-feature descriptor fields
    logic [c_DW-1:0] win [3][3];
    logic [4:0]      fx1 [3][3], fy1 [3][3], fx2 [3][3], fy2 [3][3];
    logic [c_DW-1:0] fw  [3][3];
    logic [c_DW-1:0] ft [3], fab [3], fbe [3], fst [3];
    logic            fsl [3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [c_DW-1:0] ii(input logic [4:0] y, input logic [4:0] x);
        if (y > 5'd2 || x > 5'd2) return '0;
        return win[y[1:0]][x[1:0]];
    endfunction

    task automatic load();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                scan_win[(y * 3 + x) * c_DW +: c_DW] = win[y][x];
        for (int k = 0; k < c_NF; k++)
            rom[k] = {fx1[k][0], fy1[k][0], fx2[k][0], fy2[k][0], fw[k][0],
                      fx1[k][1], fy1[k][1], fx2[k][1], fy2[k][1], fw[k][1],
                      fx1[k][2], fy1[k][2], fx2[k][2], fy2[k][2], fw[k][2],
                      ft[k], fab[k], fbe[k], fst[k], fsl[k]};
    endtask

    task automatic set_allpass(input logic [c_DW-1:0] stage0_thresh);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++) win[y][x] = '0;
        for (int k = 0; k < c_NF; k++) begin
            for (int j = 0; j < 3; j++) begin
                fx1[k][j] = '0; fy1[k][j] = '0; fx2[k][j] = '0; fy2[k][j] = '0; fw[k][j] = '0;
            end
            ft[k] = '0; fab[k] = 32'd5; fbe[k] = 32'd3; fst[k] = 32'hFFFF_FFFF;
            fsl[k] = (k != 0);
        end
        fst[1]         = stage0_thresh;
        std_dev        = $urandom;
        scan_win_index = {$urandom, $urandom};
        img_index      = 4'($urandom);
        load();
    endtask

    task automatic set_random();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++) win[y][x] = $urandom;
        for (int k = 0; k < c_NF; k++) begin
            for (int j = 0; j < 3; j++) begin
                fx1[k][j] = 5'($urandom_range(0, 3)); fy1[k][j] = 5'($urandom_range(0, 3));
                fx2[k][j] = 5'($urandom_range(0, 3)); fy2[k][j] = 5'($urandom_range(0, 3));
                fw[k][j]  = $urandom_range(0, 6) - 3;
            end
            ft[k]  = $urandom_range(0, 4) - 2;
            fab[k] = $urandom_range(0, 20) - 10;
            fbe[k] = $urandom_range(0, 20) - 10;
            fst[k] = $urandom_range(0, 24) - 12;
            fsl[k] = (k == 1) ? 1'b1 : (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        std_dev        = $urandom;
        scan_win_index = {$urandom, $urandom};
        img_index      = 4'($urandom);
        load();
    endtask

    // Walks the cascade as a plain loop over features and stages.
    task automatic model(input bit ee, output int f, output logic [c_DW-1:0] acc,
                         output logic [1:0] sp, output logic face);
        logic [c_DW-1:0] sacc, sum, prod, fv, tot, r;
        bit fail;
        sacc = '0; acc = '0; sp = '0; fail = 0; f = 0;
        for (int k = 0; k < c_NF; k++) begin
            f   = k + 1;
            sum = '0;
            for (int j = 0; j < 3; j++) begin
                r   = ii(fy2[k][j], fx2[k][j]) + ii(fy1[k][j], fx1[k][j])
                    - ii(fy1[k][j], fx2[k][j]) - ii(fy2[k][j], fx1[k][j]);
                sum = sum + r * fw[k][j];
            end
            prod = ft[k] * std_dev;
            fv   = ($signed(sum) > $signed(prod)) ? fab[k] : fbe[k];
            tot  = sacc + fv;
            if (fsl[k] || k == c_NF - 1) begin
                acc  = acc + tot;
                sacc = '0;
                if ($signed(tot) > $signed(fst[k])) sp = sp + 2'd1;
                else begin
                    fail = 1;
                    if (ee) break;
                end
            end else begin
                sacc = tot;
            end
        end
        face = !fail;
    endtask

    task automatic wait_result(input int i, input int ef, input logic [c_DW-1:0] eacc,
                               input logic [1:0] esp, input logic eface);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ov[i] && n < 40);
        chk($sformatf("latency%0d", i), 128'(n), 128'(ef + 1));
        chk($sformatf("result%0d", i),
            {ov[i], face_o[i], sp_o[i], acc_o[i], tl_o[i], pn_o[i]},
            {1'b1, eface, esp, eacc, scan_win_index, img_index});
        chk($sformatf("rom_reads%0d", i), rdmask_o[i], (16'd1 << ef) - 16'd1);
    endtask

    task automatic run_txn(input int i, input int stall);
        int              ef, n;
        logic [c_DW-1:0] eacc;
        logic [1:0]      esp;
        logic            eface;
        model(i == 0, ef, eacc, esp, eface);
        n = 0;
        while (!ir[i] && n < 10) begin
            tick();
            n++;
        end
        chk($sformatf("ready%0d", i), ir[i], 1'b1);
        in_valid[i]  = 1'b1;
        out_ready[i] = (stall == 0);
        tick();
        if (stall == 0) in_valid[i] = 1'b0;
        chk($sformatf("busy%0d", i), ir[i], 1'b0);
        wait_result(i, ef, eacc, esp, eface);
        if (stall > 0) begin
            repeat (stall) begin
                tick();
                chk($sformatf("hold%0d", i),
                    {ov[i], ir[i], face_o[i], sp_o[i], acc_o[i], tl_o[i], pn_o[i], frd[i]},
                    {1'b1, 1'b0, eface, esp, eacc, scan_win_index, img_index, 1'b0});
            end
            out_ready[i] = 1'b1;
            tick();
            chk($sformatf("no_bypass%0d", i), {ov[i], ir[i]}, 2'b01);
            tick();
            in_valid[i] = 1'b0;
            chk($sformatf("second_accept%0d", i), ir[i], 1'b0);
            wait_result(i, ef, eacc, esp, eface);
        end
        tick();
        chk($sformatf("handshake%0d", i), {ov[i], ir[i]}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 2'b00;
        out_ready = 2'b11;
        for (int k = 0; k < 16; k++) rom[k] = '0;
        set_allpass(32'hFFFF_FFFF);
        repeat (2) begin
            tick();
            for (int i = 0; i < 2; i++)
                chk($sformatf("reset%0d", i),
                    {ir[i], ov[i], frd[i], addr_o[i], face_o[i], acc_o[i], sp_o[i], tl_o[i], pn_o[i]},
                    '0);
        end
        reset_n = 1'b1;
        tick();
        chk("release_ready", ir, 2'b11);

        // all stages pass, then stage 0 fails on its threshold
        set_allpass(32'hFFFF_FFFF);
        run_txn(0, 0);
        run_txn(1, 0);
        set_allpass(32'd100);
        run_txn(0, 0);
        run_txn(1, 0);

        // result backpressure with a second window already offered
        set_allpass(32'hFFFF_FFFF);
        run_txn(0, 5);
        run_txn(1, 3);

        // reset while evaluating feature 1, then a fresh window
        for (int i = 0; i < 2; i++) begin
            set_allpass(32'hFFFF_FFFF);
            in_valid[i] = 1'b1;
            tick();
            in_valid[i] = 1'b0;
            tick();
            tick();
            reset_n = 1'b0;
            tick();
            chk($sformatf("reset_eval%0d", i), {ov[i], ir[i], frd[i]}, 3'b000);
            reset_n = 1'b1;
            tick();
            chk($sformatf("reset_eval_ready%0d", i), ir[i], 1'b1);
            run_txn(i, 0);
        end

        for (int t = 0; t < 30; t++) begin
            set_random();
            run_txn(t % 2, (t % 5 == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
